// File: rtl/counter_load_arbiter.sv
// Round-robin arbiter sharing a step/overwrite counter's load port between two
// valid/ready requesters; issues one overwrite per load and reports whether it stuck.
module counter_load_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             ctr_mode,
  output logic [WIDTH-1:0] ctr_write_data,
  input  logic [WIDTH-1:0] ctr_count,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic             busy,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             grant_a;
  logic             grant_b;
  logic             last_id;
  logic             id;
  logic [WIDTH-1:0] data;

  // Grant: a lone requester wins; on a tie the side not served last wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && (state == IDLE)) begin
      if (a_valid && (!b_valid || last_id)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b0;
      end
    end else begin
      grant_b = 1'b0;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_a || grant_b) begin
          state_next = LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD:    state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; rst gates everything so an aborted request never loads or responds.
  always_comb begin
    ctr_mode       = !rst && (state == LOAD);
    ctr_write_data = ctr_mode ? data : {WIDTH{1'b0}};
    rsp_valid      = !rst && (state == CHECK);
    rsp_id         = rsp_valid && id;
    rsp_err        = rsp_valid && (ctr_count != data);
    busy           = !rst && (state != IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request capture, round-robin pointer and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id <= 1'b1;
      id      <= 1'b0;
      data    <= {WIDTH{1'b0}};
      err_cnt <= 8'd0;
    end else begin
      if (grant_a || grant_b) begin
        id   <= grant_b;
        data <= grant_b ? b_data : a_data;
      end
      if (rsp_valid) begin
        last_id <= id;
        if (rsp_err && (err_cnt != 8'hFF)) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule
